// File: rtl/wb_queue.sv
// wb_queue: pending register-file write queue for the writeback stage.
//
// During the first cycle of a writeback phase (phase[3]) the current
// instruction is decoded.  A writing instruction pushes its
// {destination, data} pair into a DEPTH-entry FIFO.  The oldest pending
// write is presented to the register file. It retires on any cycle where
// the register file signals rf_ready.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   phase[4:0]      one-hot CPU phase; phase[3] = writeback
//   instr[15:0]     current instruction (decoded for write class/destination)
//   from_calc       ALU / shifter / LI result
//   read            load data from memory
//   rf_ready        register file accepts a write this cycle
//   rf_enable       write strobe (queue non-empty)
//   rf_addr/rf_data oldest pending write, zero when empty
//   stall           queue full while a writing instruction waits to enqueue
//   count           current occupancy 0..DEPTH
//   q_addr          bypass lookup address
//   q_hit/q_data    youngest pending write to q_addr
//
// Optional feature: define WB_QUEUE_BYPASS_EN to build the bypass lookup.
// Without it, q_hit and q_data are tied to zero and no comparators exist.
module wb_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 phase,
  input  logic [15:0]                instr,
  input  logic [DATA_W-1:0]          from_calc,
  input  logic [DATA_W-1:0]          read,
  input  logic                       rf_ready,
  output logic                       rf_enable,
  output logic [ADDR_W-1:0]          rf_addr,
  output logic [DATA_W-1:0]          rf_data,
  output logic                       stall,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [ADDR_W-1:0]          q_addr,
  output logic                       q_hit,
  output logic [DATA_W-1:0]          q_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic              taken;

  logic              writing;
  logic              is_ld;
  logic [2:0]        dest3;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic              enq;
  logic              deq;

  // Only phase[3] and the class/destination fields of instr matter here.
  logic unused_bits;
  assign unused_bits = ^{phase[4], phase[2:0], instr[3:0]};

  // Decode: write class and destination of the current instruction
  always_comb begin
    writing = 1'b0;
    is_ld   = 1'b0;
    dest3   = instr[10:8];
    if (instr[15:14] == 2'b11) begin
      // Compare and the 1101/1110/1111 group produce no register result.
      writing = !(instr[7:4] inside {4'b0101, 4'b1101, 4'b1110, 4'b1111});
    end else if (instr[15:14] == 2'b00) begin
      writing = 1'b1;
      is_ld   = 1'b1;
      dest3   = instr[13:11];
    end else if (instr[15:11] == 5'b10000) begin
      writing = 1'b1;
    end
  end

  assign wr_addr = ADDR_W'(dest3);
  assign wr_data = is_ld ? read : from_calc;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // taken blocks a second push while phase[3] is held by the sequencer.
  // A full queue never passes an entry through in the same cycle a slot frees.
  assign enq = !rst && phase[3] && writing && !taken && !full;
  assign deq = !rst && !empty && rf_ready;

  // Queue control state
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      taken <= 1'b0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (!phase[3])  taken <= 1'b0;
      else if (enq)   taken <= 1'b1;
    end
  end

  // Entry storage: data only, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wptr] <= wr_addr;
      data_mem[wptr] <= wr_data;
    end
  end

  assign rf_enable = !rst && !empty;
  assign rf_addr   = rf_enable ? addr_mem[rptr] : '0;
  assign rf_data   = rf_enable ? data_mem[rptr] : '0;
  assign stall     = !rst && phase[3] && writing && !taken && full;
  assign count     = rst ? '0 : cnt;

`ifdef WB_QUEUE_BYPASS_EN
  logic [DEPTH-1:0]  valid;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (enq) valid[wptr] <= 1'b1;
      if (deq) valid[rptr] <= 1'b0;
    end
  end

  // Walk oldest to youngest so the last match wins; the head still counts
  // on the cycle it is being written to the register file.
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (valid[idx] && (addr_mem[idx] == q_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

  assign q_hit  = !rst && hit;
  assign q_data = q_hit ? hit_data : '0;
`else
  logic unused_q;
  assign unused_q = ^q_addr;
  assign q_hit    = 1'b0;
  assign q_data   = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DATA_W=16, ADDR_W=3, DEPTH=4).
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  phase;
  logic [15:0] instr;
  logic [15:0] from_calc;
  logic [15:0] read;
  logic        rf_ready;
  logic        rf_enable;
  logic [2:0]  rf_addr;
  logic [15:0] rf_data;
  logic        stall;
  logic [2:0]  count;
  logic [2:0]  q_addr;
  logic        q_hit;
  logic [15:0] q_data;

  int n_checks = 0;
  int n_pass   = 0;

  wb_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .phase(phase), .instr(instr),
    .from_calc(from_calc), .read(read), .rf_ready(rf_ready),
    .rf_enable(rf_enable), .rf_addr(rf_addr), .rf_data(rf_data),
    .stall(stall), .count(count), .q_addr(q_addr),
    .q_hit(q_hit), .q_data(q_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle writeback pulse followed by an idle cycle.
  task automatic push(input logic [15:0] ins, input logic [15:0] calc, input logic [15:0] mem);
    instr = ins; from_calc = calc; read = mem; phase = 5'b01000;
    cyc();
    phase = 5'b00001;
    cyc();
  endtask

  logic [2:0]  exp_a [4];
  logic [15:0] exp_d [4];

  initial begin
    rst = 1'b1; phase = 5'b00001; instr = 16'h0000; from_calc = '0; read = '0;
    rf_ready = 1'b0; q_addr = '0;
    cyc(); cyc();
    #1;
    chk("rst_enable", rf_enable, 0);
    chk("rst_count",  count, 0);
    chk("rst_stall",  stall, 0);
    chk("rst_qhit",   q_hit, 0);
    chk("rst_addr",   rf_addr, 0);
    chk("rst_data",   rf_data, 0);
    rst = 1'b0;
    cyc();

    // ADD r2 with immediate retire
    instr = 16'hC200; from_calc = 16'h1234; read = 16'h5555; phase = 5'b01000; rf_ready = 1'b1;
    #1;
    chk("add_pre_enable", rf_enable, 0);
    cyc();
    phase = 5'b00001;
    #1;
    chk("add_enable", rf_enable, 1);
    chk("add_addr",   rf_addr, 2);
    chk("add_data",   rf_data, 16'h1234);
    chk("add_count",  count, 1);
    cyc();
    chk("add_empty",  rf_enable, 0);
    chk("add_empty_addr", rf_addr, 0);

    // LD r5 selects memory data
    instr = 16'h2800; from_calc = 16'h0000; read = 16'hBEEF; phase = 5'b01000;
    cyc();
    phase = 5'b00001;
    #1;
    chk("ld_addr", rf_addr, 5);
    chk("ld_data", rf_data, 16'hBEEF);
    cyc();
    chk("ld_count", count, 0);

    // CMP does not write
    push(16'hC050, 16'h7777, 16'h0000);
    chk("cmp_count",  count, 0);
    chk("cmp_enable", rf_enable, 0);

    // Fill with rf_ready low, fifth writer stalls
    rf_ready = 1'b0;
    push(16'hC100, 16'h1111, 16'h0000);  // ADD r1
    push(16'h1000, 16'h0000, 16'h2222);  // LD  r2
    push(16'h8300, 16'h3333, 16'h0000);  // LI  r3
    push(16'hC430, 16'h4444, 16'h0000);  // ADD r4 (op 0011 writes)
    chk("full_count", count, 4);
    instr = 16'h8600; from_calc = 16'h6666; phase = 5'b01000;
    #1;
    chk("full_stall", stall, 1);
    cyc();
    chk("full_stall_held", stall, 1);
    chk("full_count_held", count, 4);
    rf_ready = 1'b1;
    #1;
    chk("full_head_addr", rf_addr, 1);
    chk("full_head_data", rf_data, 16'h1111);
    cyc();
    rf_ready = 1'b0;
    #1;
    chk("free_count", count, 3);
    chk("free_stall", stall, 0);
    cyc();
    chk("late_enq_count", count, 4);
    chk("late_enq_stall", stall, 0);
    phase = 5'b00001;
    cyc();
    chk("late_enq_once", count, 4);
    exp_a[0] = 3'd2; exp_d[0] = 16'h2222;
    exp_a[1] = 3'd3; exp_d[1] = 16'h3333;
    exp_a[2] = 3'd4; exp_d[2] = 16'h4444;
    exp_a[3] = 3'd6; exp_d[3] = 16'h6666;
    rf_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", rf_addr, exp_a[i]);
      chk("drain_data", rf_data, exp_d[i]);
      cyc();
    end
    chk("drain_count", count, 0);

    // LI r1 with phase[3] held three cycles
    rf_ready = 1'b0;
    instr = 16'h8100; from_calc = 16'h0ABC; phase = 5'b01000;
    cyc(); cyc(); cyc();
    chk("hold_count", count, 1);
    phase = 5'b00001;
    rf_ready = 1'b1;
    #1;
    chk("hold_addr", rf_addr, 1);
    chk("hold_data", rf_data, 16'h0ABC);
    cyc();
    chk("hold_empty", count, 0);

    // Bypass: two pending writes to r3
    rf_ready = 1'b0;
    push(16'hC300, 16'h0011, 16'h0000);
    push(16'hC300, 16'h0022, 16'h0000);
    q_addr = 3'd3;
    #1;
`ifdef WB_QUEUE_BYPASS_EN
    chk("byp_hit",  q_hit, 1);
    chk("byp_data", q_data, 16'h0022);
`else
    chk("byp_hit_off",  q_hit, 0);
    chk("byp_data_off", q_data, 0);
`endif
    q_addr = 3'd4;
    #1;
    chk("byp_miss",      q_hit, 0);
    chk("byp_miss_data", q_data, 0);

    // Reset with three pending writes
    push(16'h8000, 16'h0005, 16'h0000);
    chk("pre_rst_count", count, 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_count",  count, 0);
    chk("post_rst_enable", rf_enable, 0);
    chk("post_rst_stall",  stall, 0);
    rf_ready = 1'b1;
    instr = 16'hC700; from_calc = 16'h0777; phase = 5'b01000;
    cyc();
    phase = 5'b00001;
    #1;
    chk("post_rst_addr", rf_addr, 7);
    chk("post_rst_data", rf_data, 16'h0777);
    cyc();
    chk("post_rst_empty", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
